// File: rtl/pulse_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_meter_pkg
//  Description : Shared definitions for the pulse meter: FSM state encoding
//                and default widths for the counters and input synchronizer.
//  Revision    : 1.0  initial release
// ============================================================================
package pulse_meter_pkg;

    // Default counter width (width/period/count registers).
    localparam int c_DEF_CNT_W       = 8;
    // Default synchronizer depth for the asynchronous pulse input.
    localparam int c_DEF_SYNC_STAGES = 2;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,    // waiting for the first rise; counters held at 0
        HIGH = 2'd1,    // inside the high phase of a pulse
        LOW  = 2'd2     // inside the low phase, waiting for the next rise
    } pm_state_t;

endpackage : pulse_meter_pkg
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Multi-stage synchronizer for an asynchronous input, followed
//                by a one-cycle history register for edge detection.
//  Ports       : clk      - sampling clock
//                rst_n    - asynchronous active-low reset (all flops to 0)
//                i_async  - asynchronous input
//                o_sync   - synchronized level (last synchronizer stage)
//                o_rise   - one-cycle pulse on a synchronized 0->1 transition
//                o_fall   - one-cycle pulse on a synchronized 1->0 transition
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge_det #(
    parameter int STAGES = 2            // 2 or more
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;

endmodule : sync_edge_det
`default_nettype wire

// File: rtl/pulse_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_meter
//  Description : Measures an asynchronous pulse train. For every complete
//                pulse (rise -> fall -> rise) it reports the high time and the
//                rise-to-rise period in clock cycles with a one-cycle strobe,
//                keeps a saturating count of reports and a sticky overflow
//                flag for saturated measurements.
//  Ports       : clock        - measurement clock
//                reset_n      - asynchronous active-low reset
//                pulse_in     - asynchronous pulse train under measurement
//                clear        - synchronous clear of count/overflow, FSM->IDLE
//                width        - high time of the last complete pulse
//                period       - rise-to-rise time of the last complete pulse
//                meas_valid   - one-cycle strobe, width/period updated
//                pulse_count  - number of completed measurements (saturating)
//                overflow     - sticky, a width/period counter saturated
//  Revision    : 1.0  initial release
// ============================================================================
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W       = c_DEF_CNT_W,
    parameter int SYNC_STAGES = c_DEF_SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pulse_in,
    input  logic             clear,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic [CNT_W-1:0] pulse_count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic w_s;
    logic w_rise;
    logic w_fall;

    pm_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_wcnt,  w_wcnt_nxt;
    logic [CNT_W-1:0] r_pcnt,  w_pcnt_nxt;
    logic             r_ovf_cur, w_ovf_cur_nxt;
    logic             w_report;

    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clock),
        .rst_n   (reset_n),
        .i_async (pulse_in),
        .o_sync  (w_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    // ------------------------------------------------------------------
    // FSM state and measurement counters
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_wcnt    <= '0;
            r_pcnt    <= '0;
            r_ovf_cur <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_ovf_cur <= w_ovf_cur_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wcnt_nxt    = r_wcnt;
        w_pcnt_nxt    = r_pcnt;
        w_ovf_cur_nxt = r_ovf_cur;
        w_report      = 1'b0;

        if (clear) begin
            // clear wins over a rise detected in the same cycle
            w_state_nxt   = IDLE;
            w_wcnt_nxt    = '0;
            w_pcnt_nxt    = '0;
            w_ovf_cur_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_wcnt_nxt    = '0;
                    w_pcnt_nxt    = '0;
                    w_ovf_cur_nxt = 1'b0;
                    // Only a rise starts a measurement, so a partial first
                    // pulse is never reported.
                    if (w_rise) begin
                        w_state_nxt = HIGH;
                        w_wcnt_nxt  = c_CNT_ONE;
                        w_pcnt_nxt  = c_CNT_ONE;
                    end
                end

                HIGH: begin
                    if (w_fall) begin
                        w_state_nxt = LOW;
                        if (r_pcnt == c_CNT_MAX) w_ovf_cur_nxt = 1'b1;
                        else                     w_pcnt_nxt    = r_pcnt + c_CNT_ONE;
                    end else if (w_s) begin
                        if (r_wcnt == c_CNT_MAX) w_ovf_cur_nxt = 1'b1;
                        else                     w_wcnt_nxt    = r_wcnt + c_CNT_ONE;
                        if (r_pcnt == c_CNT_MAX) w_ovf_cur_nxt = 1'b1;
                        else                     w_pcnt_nxt    = r_pcnt + c_CNT_ONE;
                    end
                end

                LOW: begin
                    if (w_rise) begin
                        // The rise closes this pulse and opens the next one.
                        w_report      = 1'b1;
                        w_state_nxt   = HIGH;
                        w_wcnt_nxt    = c_CNT_ONE;
                        w_pcnt_nxt    = c_CNT_ONE;
                        w_ovf_cur_nxt = 1'b0;
                    end else begin
                        if (r_pcnt == c_CNT_MAX) w_ovf_cur_nxt = 1'b1;
                        else                     w_pcnt_nxt    = r_pcnt + c_CNT_ONE;
                    end
                end

                default: begin
                    w_state_nxt   = IDLE;
                    w_wcnt_nxt    = '0;
                    w_pcnt_nxt    = '0;
                    w_ovf_cur_nxt = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Reported results, count and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_width    <= '0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= w_report;
            if (clear) begin
                // width/period intentionally keep their last values
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else if (w_report) begin
                r_width    <= r_wcnt;
                r_period   <= r_pcnt;
                r_overflow <= r_overflow | r_ovf_cur;
                if (r_count != c_CNT_MAX) r_count <= r_count + c_CNT_ONE;
            end
        end
    end

    assign width       = r_width;
    assign period      = r_period;
    assign meas_valid  = r_valid;
    assign pulse_count = r_count;
    assign overflow    = r_overflow;

endmodule : pulse_meter
`default_nettype wire

// File: doc/pulse_meter.md
Name: pulse_meter

Overview:
- Downstream consumer of the pulse generator stage: samples an external pulse train on `pulse_in` and measures it.
- Per complete pulse it reports high-time (width) and rising-edge-to-rising-edge time (period) in `clock` cycles, with a one-cycle valid strobe.
- Also keeps a running pulse count and a sticky overflow flag.
- Feeds test/monitor logic that checks the generator's duty cycle, e.g. 5 high / 24 period at the generator's timebase.

Parameters:
- CNT_W, 8, width of the width/period/count registers; counts saturate at 2**CNT_W-1.
- SYNC_STAGES, 2, flip-flop stages in the `pulse_in` synchronizer; legal values are 2 or more.

Ports:
- clock  input  1  measurement clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- pulse_in  input  1  asynchronous pulse train under measurement.
- clear  input  1  synchronous; clears pulse_count and overflow, and returns the FSM to IDLE.
- width  output  CNT_W  high-time of the last complete pulse, in cycles.
- period  output  CNT_W  rise-to-rise time of the last complete pulse, in cycles.
- meas_valid  output  1  one-cycle strobe; width/period updated this cycle.
- pulse_count  output  CNT_W  number of completed measurements; saturating.
- overflow  output  1  sticky; set if any width or period counter saturated.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All synchronizer flops, the edge register, wcnt and pcnt go to 0.
  - Outputs: width=0, period=0, meas_valid=0, pulse_count=0, overflow=0.
  - state=IDLE.
- Synchronizer: s = last stage of a SYNC_STAGES chain; prev <= s.
  - rise = s & ~prev; fall = ~s & prev.
  - A cycle-aligned `pulse_in` edge appears on rise/fall exactly SYNC_STAGES cycles later.
- Internal counters wcnt, pcnt are CNT_W bits. Increment saturates at all-ones; any saturating increment sets ovf_cur.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: counters held at 0. On rise go to HIGH with wcnt=1, pcnt=1. Any edge before the first rise is ignored, so a partial first pulse is never reported.
  - HIGH: wcnt++ and pcnt++ each cycle s=1. On fall go to LOW, wcnt frozen, pcnt++.
  - LOW: pcnt++ each cycle. On rise:
    - width<=wcnt, period<=pcnt, meas_valid<=1 for one cycle.
    - pulse_count++ (saturating).
    - overflow<=overflow|ovf_cur.
    - Go to HIGH with wcnt=1, pcnt=1, ovf_cur=0.
- Latency: meas_valid is asserted in the cycle after the rise is detected, i.e. SYNC_STAGES+1 cycles after the cycle-aligned `pulse_in` rise.
- width/period hold their values between strobes.
- meas_valid must never be high on two consecutive cycles. Minimum legal period is 2 cycles (1 high, 1 low).
- clear has priority over a simultaneous rise:
  - FSM goes to IDLE; wcnt, pcnt and ovf_cur go to 0.
  - pulse_count=0, overflow=0, no strobe.
  - width/period keep their last values.
- Saturation: a stuck-high or stuck-low input leaves the counter at the maximum value. The measurement is still reported at the next rise, with overflow set.
- reset_n deasserted mid-pulse: the FSM restarts in IDLE and the first report comes only after two subsequent rises.

Decomposition:
- Shared package `pulse_meter_pkg`:
  - State encoding constants IDLE=2'd0, HIGH=2'd1, LOW=2'd2.
  - Default CNT_W and SYNC_STAGES.
- Sub-module `sync_edge_det`: parameterised synchronizer plus prev register, outputs s/rise/fall. Reusable for other asynchronous inputs.
- FSM and counters live in the top module.

Test Plan:
- Reset, then cycle-aligned pulse_in of 3 high / 9 low repeated 4 times:
  - Strobes start after the second rise.
  - Each strobe gives width=3, period=12.
  - pulse_count reaches 3, overflow=0.
- 1 high / 1 low (minimum period):
  - width=1, period=2 on every strobe.
  - meas_valid never high on consecutive cycles.
- CNT_W=4, pulse_in held high 20 cycles, then 2 low, then rise:
  - width=15, period=15, overflow=1.
  - overflow stays 1 until clear.
- clear asserted in the same cycle as a detected rise:
  - No strobe; pulse_count=0, overflow=0.
  - The next report comes only after two further rises.
- reset_n pulsed low asynchronously mid-HIGH (between clock edges):
  - All outputs are 0 immediately.
  - The first strobe follows the second subsequent rise with correct values.
- pulse_in from the 5-high/24-period generator, with a measurement clock of period 1 time unit:
  - width=5 ±1, period=24 on every strobe.
  - Check the waveform in GTKWave.
